// File: rtl/ag32gbd_pkg.sv
// ag32gbd shared definitions: control FSM encoding and
// default buffer-ring sizing.
package ag32gbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_DATA
  } state_t;

  localparam int DEF_NUM_BUFS  = 2;
  localparam int DEF_BUF_BYTES = 256;
  localparam int DEF_DATA_W    = 8;

endpackage

// File: rtl/ag32gbd_spram.sv
// Single-port RAM with registered read data; the read
// returns the old contents when the same address is written.
module ag32gbd_spram
  import ag32gbd_pkg::*;
#(
  parameter int DEPTH  = DEF_NUM_BUFS * DEF_BUF_BYTES,
  parameter int DATA_W = DEF_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              sys_clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge sys_clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ag32gbd_buf_ring.sv
// Ring of tile buffers in one shared RAM: a producer fills and
// commits buffers, a consumer reads and releases them in order.
module ag32gbd_buf_ring
  import ag32gbd_pkg::*;
#(
  parameter int NUM_BUFS  = DEF_NUM_BUFS,
  parameter int BUF_BYTES = DEF_BUF_BYTES,
  parameter int DATA_W    = DEF_DATA_W,
  localparam int OFS_W    = $clog2(BUF_BYTES),
  localparam int IDX_W    = $clog2(NUM_BUFS),
  localparam int FC_W     = IDX_W + 1,
  localparam int AW       = $clog2(NUM_BUFS * BUF_BYTES)
) (
  input  logic              sys_clock,
  input  logic              resetn,
  input  logic              wr_req,
  input  logic [OFS_W-1:0]  wr_offset,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  input  logic              wr_commit,
  output logic              wr_full,
  input  logic              rd_req,
  input  logic [OFS_W-1:0]  rd_offset,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              rd_avail,
  output logic [FC_W-1:0]   fill_count,
  output logic              overflow,
  input  logic              ovf_clear
);

  state_t state, state_nx;

  logic              prio, prio_nx;
  logic              wr_pend, rd_pend, rd_ready;
  logic [OFS_W-1:0]  wr_ofs_q, rd_ofs_q;
  logic [DATA_W-1:0] wr_dat_q, ram_q;
  logic [IDX_W-1:0]  wr_idx, rd_idx, wr_buf, rd_buf;
  logic [AW-1:0]     ram_addr;
  logic              ram_we, commit_ok, release_ok;

  assign wr_full    = (fill_count == FC_W'(NUM_BUFS - 1));
  assign rd_avail   = (fill_count != '0);
  assign commit_ok  = wr_commit & ~wr_full;
  assign release_ok = rd_release & rd_avail;
  assign rd_ready   = rd_pend & rd_avail;

  assign ram_we   = (state == ST_WRITE);
  assign ram_addr = ram_we ? {wr_buf, wr_ofs_q}
                           : {rd_buf, rd_ofs_q};

  ag32gbd_spram #(
    .DEPTH  (NUM_BUFS * BUF_BYTES),
    .DATA_W (DATA_W)
  ) u_ram (
    .sys_clock (sys_clock),
    .we        (ram_we),
    .addr      (ram_addr),
    .wdata     (wr_dat_q),
    .rdata     (ram_q)
  );

  // prio=0 favours the write when both are pending
  always_comb begin
    state_nx = state;
    prio_nx  = prio;
    unique case (state)
      ST_IDLE: begin
        if (wr_pend && rd_ready) begin
          prio_nx  = ~prio;
          state_nx = prio ? ST_RD_ADDR : ST_WRITE;
        end else if (wr_pend) begin
          state_nx = ST_WRITE;
        end else if (rd_ready) begin
          state_nx = ST_RD_ADDR;
        end
      end
      ST_WRITE:   state_nx = ST_IDLE;
      ST_RD_ADDR: state_nx = ST_RD_DATA;
      ST_RD_DATA: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      prio     <= 1'b0;
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wr_pend  <= 1'b0;
      rd_pend  <= 1'b0;
      wr_ofs_q <= '0;
      wr_dat_q <= '0;
      rd_ofs_q <= '0;
      wr_buf   <= '0;
      rd_buf   <= '0;
    end else begin
      state    <= state_nx;
      prio     <= prio_nx;
      wr_done  <= (state == ST_WRITE);
      rd_valid <= (state == ST_RD_DATA);
      if (state == ST_RD_DATA) rd_data <= ram_q;

      if (state == ST_WRITE) begin
        wr_pend <= 1'b0;
      end else if (wr_req && !wr_pend) begin
        wr_pend  <= 1'b1;
        wr_ofs_q <= wr_offset;
        wr_dat_q <= wr_data;
        wr_buf   <= wr_idx;
      end

      // a read left pending after its buffer was released is dropped
      if (state == ST_RD_DATA ||
          (state == ST_IDLE && rd_pend && !rd_avail)) begin
        rd_pend <= 1'b0;
      end else if (rd_req && !rd_pend && rd_avail) begin
        rd_pend  <= 1'b1;
        rd_ofs_q <= rd_offset;
        rd_buf   <= rd_idx;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (commit_ok)  wr_idx <= wr_idx + 1'b1;
      if (release_ok) rd_idx <= rd_idx + 1'b1;
      if (commit_ok && !release_ok)
        fill_count <= fill_count + 1'b1;
      else if (release_ok && !commit_ok)
        fill_count <= fill_count - 1'b1;
      if (wr_commit && wr_full) overflow <= 1'b1;
      else if (ovf_clear)       overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ag32gbd_buf_ring.sv
// Bench for ag32gbd_buf_ring: table vectors, a read scoreboard
// and hand sequences for arbitration, overflow, wrap and reset.
`timescale 1ns/1ps
module tb_ag32gbd_buf_ring;

  logic       sys_clock = 1'b0;
  logic       resetn;
  logic       wr_req, wr_commit, rd_req, rd_release, ovf_clear;
  logic [7:0] wr_offset, wr_data, rd_offset;

  logic       wr_done, wr_full, rd_valid, rd_avail, overflow;
  logic [7:0] rd_data;
  logic [1:0] fill_count;

  logic       wr_done4, wr_full4, rd_valid4, rd_avail4, overflow4;
  logic [7:0] rd_data4;
  logic [2:0] fill_count4;

  always #5 sys_clock = ~sys_clock;

  ag32gbd_buf_ring dut (
    .sys_clock  (sys_clock),
    .resetn     (resetn),
    .wr_req     (wr_req),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_commit  (wr_commit),
    .wr_full    (wr_full),
    .rd_req     (rd_req),
    .rd_offset  (rd_offset),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_release (rd_release),
    .rd_avail   (rd_avail),
    .fill_count (fill_count),
    .overflow   (overflow),
    .ovf_clear  (ovf_clear)
  );

  ag32gbd_buf_ring #(.NUM_BUFS(4)) dut4 (
    .sys_clock  (sys_clock),
    .resetn     (resetn),
    .wr_req     (wr_req),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data),
    .wr_done    (wr_done4),
    .wr_commit  (wr_commit),
    .wr_full    (wr_full4),
    .rd_req     (rd_req),
    .rd_offset  (rd_offset),
    .rd_data    (rd_data4),
    .rd_valid   (rd_valid4),
    .rd_release (rd_release),
    .rd_avail   (rd_avail4),
    .fill_count (fill_count4),
    .overflow   (overflow4),
    .ovf_clear  (ovf_clear)
  );

  typedef struct {
    logic [7:0] ofs;
    logic [7:0] wdat;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [7];
  int         n_pass = 0;
  int         n_chk  = 0;
  int         rv_cnt = 0;
  bit         mon_main = 1'b1;
  bit         use4 = 1'b0;
  bit         log_ev = 1'b0;
  bit         hold = 1'b0;
  logic [7:0] q  [$];
  logic [7:0] q4 [$];
  bit         ev [$];
  bit         exp_pr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int         base;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic ctl(bit c, bit r, bit o);
    wr_commit = c; rd_release = r; ovf_clear = o;
    tick();
    wr_commit = 0; rd_release = 0; ovf_clear = 0;
  endtask

  task automatic do_write(logic [7:0] o, logic [7:0] d);
    wr_req = 1; wr_offset = o; wr_data = d;
    tick();
    wr_req = 0;
    tick(2);
    chk("wr_done", use4 ? wr_done4 : wr_done, 1);
    tick();
  endtask

  task automatic do_read(logic [7:0] o, logic [7:0] e);
    if (use4) q4.push_back(e);
    else q.push_back(e);
    rd_req = 1; rd_offset = o;
    tick();
    rd_req = 0;
    tick(4);
  endtask

  // scoreboard: every rd_valid pops the oldest expected read
  always @(negedge sys_clock) begin
    if (rd_valid) begin
      rv_cnt++;
      if (mon_main) begin
        if (log_ev) ev.push_back(1'b1);
        if (hold) begin
          chk("hold_rd_data", rd_data, 8'h11);
        end else if (q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_rd_valid: rd_data=%0h, none outstanding", rd_data);
        end else begin
          chk("rd_data", rd_data, q.pop_front());
        end
      end
    end
    if (wr_done && mon_main && log_ev) ev.push_back(1'b0);
    if (rd_valid4 && use4) begin
      if (q4.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_rd_valid4: rd_data=%0h, none outstanding", rd_data4);
      end else begin
        chk("rd_data4", rd_data4, q4.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h00, 8'h3C, 8'h3C};
    tbl[1] = '{8'hFF, 8'hC3, 8'hC3};
    tbl[2] = '{8'h01, 8'h55, 8'h66};
    tbl[3] = '{8'h80, 8'hAA, 8'hAA};
    tbl[4] = '{8'h7F, 8'h00, 8'h00};
    tbl[5] = '{8'hFE, 8'hFF, 8'hFF};
    tbl[6] = '{8'h01, 8'h66, 8'h66};

    resetn = 0; wr_req = 0; rd_req = 0;
    wr_commit = 0; rd_release = 0; ovf_clear = 0;
    wr_offset = 0; wr_data = 0; rd_offset = 0;
    tick(2);
    chk("rst_fill", fill_count, 0);
    chk("rst_avail", rd_avail, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_done", wr_done, 0);
    resetn = 1;
    tick();

    // write, commit, read with exact latencies
    wr_req = 1; wr_offset = 8'h10; wr_data = 8'hA5;
    tick();
    wr_req = 0;
    tick(); chk("wr_lat1", wr_done, 0);
    tick(); chk("wr_lat2", wr_done, 1);
    tick(); chk("wr_done_pulse", wr_done, 0);
    ctl(1, 0, 0);
    chk("commit_fill", fill_count, 1);
    chk("commit_full", wr_full, 1);
    chk("commit_avail", rd_avail, 1);
    q.push_back(8'hA5);
    rd_req = 1; rd_offset = 8'h10;
    tick();
    rd_req = 0;
    tick(2); chk("rd_lat2", rd_valid, 0);
    tick(); chk("rd_lat3", rd_valid, 1);
    chk("rd_lat3_data", rd_data, 8'hA5);
    tick(); chk("rd_valid_pulse", rd_valid, 0);
    ctl(0, 1, 0);
    chk("release_fill", fill_count, 0);

    // table vectors through the next buffer
    for (int i = 0; i < 7; i++) do_write(tbl[i].ofs, tbl[i].wdat);
    ctl(1, 0, 0);
    for (int i = 0; i < 7; i++) do_read(tbl[i].ofs, tbl[i].exp);
    ctl(0, 1, 0);
    chk("tbl_fill", fill_count, 0);

    // overflow on a full ring; clear and set-wins
    ctl(1, 0, 0);
    chk("ovf_full", wr_full, 1);
    ctl(1, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_fill", fill_count, 1);
    ctl(0, 0, 1);
    chk("ovf_clear", overflow, 0);
    ctl(1, 0, 1);
    chk("ovf_set_wins", overflow, 1);
    ctl(0, 0, 1);
    chk("ovf_clear2", overflow, 0);
    ctl(0, 1, 0);
    do_write(8'h80, 8'h77);
    ctl(1, 0, 0);
    do_read(8'h80, 8'h77);
    ctl(0, 1, 0);

    // read with nothing committed is discarded
    base = rv_cnt;
    rd_req = 1; rd_offset = 8'h00;
    tick();
    rd_req = 0;
    tick(5);
    chk("empty_no_rd_valid", rv_cnt, base);
    chk("empty_avail", rd_avail, 0);

    // arbitration: paired requests alternate priority
    do_write(8'h05, 8'h11);
    ctl(1, 0, 0);
    ev.delete();
    log_ev = 1;
    q.push_back(8'h11);
    wr_req = 1; wr_offset = 8'h06; wr_data = 8'h22;
    rd_req = 1; rd_offset = 8'h05;
    tick();
    wr_req = 0; rd_req = 0;
    tick(10);
    q.push_back(8'h11);
    wr_req = 1; wr_offset = 8'h07; wr_data = 8'h33;
    rd_req = 1; rd_offset = 8'h05;
    tick();
    wr_req = 0; rd_req = 0;
    tick(10);
    chk("pair_ev_n", ev.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("pair_order", (i < ev.size()) ? int'(ev[i]) : 2, exp_pr[i]);

    // requests held high: services alternate W,R,W,R
    ev.delete();
    hold = 1;
    wr_req = 1; wr_offset = 8'h08; wr_data = 8'h44;
    rd_req = 1; rd_offset = 8'h05;
    tick(30);
    wr_req = 0; rd_req = 0;
    tick(12);
    hold = 0; log_ev = 0;
    chk("hold_ev_min", int'(ev.size() >= 8), 1);
    for (int i = 0; i < ev.size(); i++)
      chk("hold_alt", ev[i], i % 2);
    ctl(0, 1, 0);
    ctl(1, 0, 0);
    do_read(8'h06, 8'h22);
    do_read(8'h07, 8'h33);
    do_read(8'h08, 8'h44);
    chk("q_empty", q.size(), 0);

    // reset while in RD_DATA abandons the read
    ctl(1, 0, 0);
    chk("pre_rst_ovf", overflow, 1);
    rd_req = 1; rd_offset = 8'h06;
    tick();
    rd_req = 0;
    tick(2);
    base = rv_cnt;
    resetn = 0;
    #1;
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_fill", fill_count, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_avail", rd_avail, 0);
    chk("arst_wr_done", wr_done, 0);
    tick(3);
    chk("arst_no_rd_valid", rv_cnt, base);
    resetn = 1;
    tick();

    // four-buffer ring: wrap 3->0 and data kept in buffer 0
    mon_main = 0; use4 = 1;
    for (int k = 0; k < 4; k++) begin
      do_write(8'h30, 8'hB0 + 8'(k));
      ctl(1, 0, 0);
      chk("ring4_fill1", fill_count4, 1);
      do_read(8'h30, 8'hB0 + 8'(k));
      ctl(0, 1, 0);
      chk("ring4_fill0", fill_count4, 0);
    end
    do_write(8'h31, 8'hC5);
    ctl(1, 0, 0);
    do_read(8'h31, 8'hC5);
    do_read(8'h30, 8'hB0);
    ctl(1, 1, 0);
    chk("ring4_cr_fill", fill_count4, 1);
    ctl(1, 0, 0);
    ctl(1, 0, 0);
    chk("ring4_fill3", fill_count4, 3);
    chk("ring4_full", wr_full4, 1);
    ctl(1, 0, 0);
    chk("ring4_ovf", overflow4, 1);
    chk("ring4_ovf_fill", fill_count4, 3);
    chk("q4_empty", q4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ag32gbd_buf_ring.md
AG32GBD_BUF_RING -- requirements
Module: ag32gbd_buf_ring

Interface
REQ-001 SHALL have parameter NUM_BUFS, default 2, number of tile buffers (2..8, power of two).
REQ-002 SHALL have parameter BUF_BYTES, default 256, bytes per buffer (power of two); OFS_W = log2(BUF_BYTES).
REQ-003 SHALL have parameter DATA_W, default 8, data width.
REQ-004 SHALL have ports: sys_clock  in  1  single clock; resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have producer ports: wr_req in 1 write strobe; wr_offset in OFS_W byte offset; wr_data in DATA_W; wr_done out 1 one-cycle write ack; wr_commit in 1 hand current write buffer to consumer; wr_full out 1 no free buffer.
REQ-006 SHALL have consumer ports: rd_req in 1 read strobe; rd_offset in OFS_W; rd_data out DATA_W; rd_valid out 1 one-cycle data-ready; rd_release in 1 free current read buffer; rd_avail out 1 committed buffer present.
REQ-007 SHALL have status ports: fill_count out log2(NUM_BUFS)+1 committed buffers; overflow out 1 sticky; ovf_clear in 1.

Function
REQ-008 Storage SHALL be one single-port RAM of NUM_BUFS*BUF_BYTES words; address = {buffer index, offset}.
REQ-009 Control FSM SHALL have states IDLE, WRITE, RD_ADDR, RD_DATA.
REQ-010 IDLE: wr_req pending -> WRITE; else rd_req pending and rd_avail -> RD_ADDR; else stay.
REQ-011 Requests SHALL be latched (with offset/data) when asserted, held pending until serviced; new req while pending is ignored.
REQ-012 WRITE SHALL write RAM at {wr_idx, offset}, pulse wr_done next cycle, return to IDLE; write latency 2 cycles from wr_req.
REQ-013 RD_ADDR presents {rd_idx, offset}; RD_DATA registers RAM output to rd_data and pulses rd_valid; read latency 3 cycles from rd_req.
REQ-014 Simultaneous pending write and read: write SHALL win once; next arbitration SHALL prefer read (alternating priority bit toggles on each service when both pending).
REQ-015 rd_req with rd_avail=0 SHALL be discarded, no rd_valid.
REQ-016 wr_commit with wr_full=0: wr_idx increments modulo NUM_BUFS, fill_count +1.
REQ-017 wr_commit with wr_full=1: commit dropped, wr_idx unchanged, overflow set; producer overwrites same buffer.
REQ-018 rd_release with rd_avail=1: rd_idx increments modulo NUM_BUFS, fill_count -1; with rd_avail=0 ignored.
REQ-019 Same-cycle commit and release (both valid): both indices advance, fill_count unchanged.
REQ-020 wr_full = (fill_count == NUM_BUFS-1); rd_avail = (fill_count != 0); both combinational from registered count.
REQ-021 overflow clears on ovf_clear; set wins if same cycle.
REQ-022 Commit/release SHALL NOT wait for FSM; a write in flight completes into the buffer latched at request time.

Reset
REQ-023 On resetn low, immediately: state IDLE, wr_idx=rd_idx=0, fill_count=0, pending flags 0, wr_done=rd_valid=0, rd_data=0, overflow=0, priority=write.
REQ-024 Reset mid-transaction SHALL abandon it with no ack; RAM contents undefined after reset.

Structure
REQ-025 FSM state encoding and default parameter constants SHALL live in shared package ag32gbd_pkg.
REQ-026 RAM SHALL be sub-module ag32gbd_spram (params DEPTH, DATA_W; registered read, one port).

Verification
REQ-027 Write 0xA5 at offset 0x10, commit, read offset 0x10 -> wr_done at cycle 2, rd_valid at cycle 3, rd_data=0xA5.
REQ-028 NUM_BUFS=2: commit twice without release -> wr_full=1 after first, second sets overflow, fill_count stays 1.
REQ-029 wr_req and rd_req same cycle repeatedly -> services alternate W,R,W,R; no request lost.
REQ-030 NUM_BUFS=4: 4 commits/releases interleaved -> indices wrap 3->0, data in buffer 0 readable after wrap.
REQ-031 rd_req with fill_count=0 -> no rd_valid within 5 cycles; simultaneous commit+release at fill_count=1 -> stays 1.
REQ-032 Assert resetn low during RD_DATA -> rd_valid never pulses, all outputs at reset values same cycle.
